// File: rtl/lowmem_responder.sv
// Block-organised backing store for the cache "Low" port: one request at a time, fixed latency.
// Optional protocol checker on Err_Low is built only when LOWMEM_PROTO_CHECK_EN is defined.

// state | meaning
// IDLE  | waiting for Req_Low; captures op, index and write data on acceptance
// BUSY  | latency countdown; the array is written or read when the counter reaches 0
// DONE  | Rdy_Low high for this single cycle; Req_Low ignored, always returns to IDLE
module lowmem_responder #(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 8,
  parameter int BLK_W   = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Req_Low,
  input  logic             Wr_Low,
  input  logic [27:0]      A_Low,
  input  logic [BLK_W-1:0] D_Low_In,
  output logic [BLK_W-1:0] D_Low_Out,
  output logic             Rdy_Low,
  output logic             Err_Low
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic             wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [BLK_W-1:0] wdata_q;
  logic [BLK_W-1:0] dout_q;
  logic             rdy_q;
  logic             mem_we_d;

  logic [BLK_W-1:0] mem_q [2**IDX_W];

  // Upper address bits alias onto the same block.
  logic unused_addr_hi;
  assign unused_addr_hi = ^A_Low[27:IDX_W];

  assign mem_we_d = (state_q == BUSY) && (cnt_q == 8'd0) && wr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Req_Low) begin
            wr_q  <= Wr_Low;
            idx_q <= A_Low[IDX_W-1:0];
            if (Wr_Low) wdata_q <= D_Low_In;
            cnt_q   <= CNT_LOAD;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 8'd0) begin
            if (!wr_q) dout_q <= mem_q[idx_q];
            rdy_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; an aborted transfer never raises mem_we_d.
  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[idx_q] <= wdata_q;
  end

  assign D_Low_Out = dout_q;
  assign Rdy_Low   = rdy_q;

`ifdef LOWMEM_PROTO_CHECK_EN
  logic [27:0] addr_q;
  logic        err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= 28'd0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && Req_Low) addr_q <= A_Low;
      if ((state_q == BUSY && (!Req_Low || Wr_Low != wr_q || A_Low != addr_q)) ||
          (rdy_q && !Req_Low))
        err_q <= 1'b1;
    end
  end

  assign Err_Low = err_q;
`else
  assign Err_Low = 1'b0;
`endif

endmodule
